// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory port arbiter.
// ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Grant index width, never below one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotate-priority picker: first requester at or after i_ptr wins.
// Under ARB_FIXED_PRIO_EN the top ties i_ptr to zero.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    int                w_j;
    logic [NUM_CH-1:0] w_sh;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        w_sh  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_CH) w_j = w_j - NUM_CH;
            w_sh = i_req >> w_j;
            if (w_sh[0]) begin
                o_gnt = NUM_CH'(1) << w_j;
                o_idx = IDX_W'(w_j);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// NUM_CH cache ports sharing one slow memory port, one transaction in flight.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     proc_reset,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int IDX_W = clog2(NUM_CH);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [IDX_W-1:0]  r_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_ch_rdata;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_ptr;
    logic              w_any;
    logic              w_wr_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_req    = ch_read | ch_write;
    assign w_wr_sel = |(ch_write & w_gnt);
    assign w_addr   = ADDR_W'(ch_addr >> (int'(w_idx) * ADDR_W));
    assign w_wdata  = DATA_W'(ch_wdata >> (int'(w_idx) * DATA_W));

    rr_pick #(
        .NUM_CH(NUM_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req(w_req),
        .i_ptr(w_ptr),
        .o_gnt(w_gnt),
        .o_idx(w_idx),
        .o_any(w_any)
    );

`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
            r_rr_ptr <= '0;
        else if (r_state == RESP)
            r_rr_ptr <= (r_grant == IDX_W'(NUM_CH - 1)) ?
                        '0 : r_grant + 1'b1;
    end

    assign w_ptr = r_rr_ptr;
`endif

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = BUSY;
            BUSY:    if (mem_ready) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ch_ready = '0;
        if (r_state == RESP) ch_ready = NUM_CH'(1) << r_grant;
    end

    // Write wins when a channel raises both read and write.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_grant     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ch_rdata  <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_grant     <= w_idx;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_write <= w_wr_sel;
            r_mem_read  <= !w_wr_sel;
        end else if (r_state == BUSY && mem_ready) begin
            if (r_mem_read) r_ch_rdata <= mem_rdata;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ch_rdata  = r_ch_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with three channels and a behavioural memory.
// Grant expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 28;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            proc_reset;
    logic [N-1:0]    ch_read;
    logic [N-1:0]    ch_write;
    logic [N*AW-1:0] ch_addr;
    logic [N*DW-1:0] ch_wdata;
    logic [DW-1:0]   ch_rdata;
    logic [N-1:0]    ch_ready;
    logic            mem_read;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_CH(N),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .ch_read   (ch_read),
        .ch_write  (ch_write),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_ready  (ch_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {4{4'hC, a}};
    endfunction

    // Reference arbitration rule.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int p;
        p = ptr;
`ifdef ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < N; k++)
            if (req[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Memory responder: mem_ready after lat strobe cycles.
    int            lat      = 4;
    bit            rand_lat = 0;
    bit            spur     = 0;
    bit            use_ovr  = 0;
    logic [DW-1:0] ovr      = '0;
    logic          txn_rd   = 0;
    logic          txn_wr   = 0;
    logic [AW-1:0] txn_addr = '0;
    logic [DW-1:0] txn_wdata = '0;
    int            rcnt;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        rcnt = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (proc_reset || !(mem_read || mem_write)) begin
                rcnt = 0;
                if (spur && !proc_reset && $urandom_range(0, 1) == 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = {4{$urandom()}};
                end
            end else begin
                rcnt++;
                if (rcnt >= lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = use_ovr ? ovr : mdata(mem_addr);
                    txn_rd    = mem_read;
                    txn_wr    = mem_write;
                    txn_addr  = mem_addr;
                    txn_wdata = mem_wdata;
                    rcnt = 0;
                    if (rand_lat) lat = $urandom_range(1, 5);
                end
            end
        end
    end

    logic          rq_rd[N];
    logic          rq_wr[N];
    logic [AW-1:0] rq_a[N];
    logic [DW-1:0] rq_d[N];
    int            m_ptr = 0;
    logic [DW-1:0] m_rdata = '0;

    task automatic set_req(input int c, input logic rd, input logic wr,
                           input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        rq_rd[c] = rd;
        rq_wr[c] = wr;
        rq_a[c]  = a;
        rq_d[c]  = d;
        ch_read[c]  = rd;
        ch_write[c] = wr;
        ch_addr[c*AW +: AW]  = a;
        ch_wdata[c*DW +: DW] = d;
    endtask

    task automatic rand_req(input int c);
        int op;
        op = $urandom_range(0, 2);
        set_req(c, op != 1, op != 0, AW'($urandom()), {4{$urandom()}});
    endtask

    task automatic wait_ready(output int idx, output int n);
        idx = -1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (ch_ready != '0) break;
        end
        if (ch_ready == '0) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout observed=none expected=pulse");
        end else begin
            chk("ready_onehot", $countones(ch_ready), 1);
            for (int i = 0; i < N; i++) if (ch_ready[i]) idx = i;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
    endtask

    task automatic model_txn(input int mode);
        logic [N-1:0] req;
        int exp, got, n;
        logic ewr;
        for (int c = 0; c < N; c++) req[c] = rq_rd[c] | rq_wr[c];
        exp = pick(req, m_ptr);
        wait_ready(got, n);
        chk("grant", got, exp);
        if (exp >= 0) begin
            ewr = rq_wr[exp];
            chk("op_wr", txn_wr, ewr);
            chk("op_rd", txn_rd, !ewr);
            chk("addr", txn_addr, rq_a[exp]);
            if (ewr) chk("wdata", txn_wdata, rq_d[exp]);
            else m_rdata = mdata(rq_a[exp]);
            chk("rdata", ch_rdata, m_rdata);
            m_ptr = (exp + 1) % N;
            if (mode == 0 || $urandom_range(0, 2) != 0) rand_req(exp);
            else set_req(exp, 0, 0, '0, '0);
            for (int c = 0; c < N; c++)
                if (mode == 1 && c != exp && !(rq_rd[c] | rq_wr[c])
                    && $urandom_range(0, 1) == 1)
                    rand_req(c);
            for (int c = 0; c < N; c++) req[c] = rq_rd[c] | rq_wr[c];
            if (req == '0) rand_req($urandom_range(0, N - 1));
        end
        @(negedge clk);
        chk("ready_pulse", ch_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, n;
        proc_reset = 1'b1;
        ch_read = '0;
        ch_write = '0;
        ch_addr = '0;
        ch_wdata = '0;
        for (int c = 0; c < N; c++) set_req(c, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_ch_ready", ch_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ch_rdata", ch_rdata, 0);
        proc_reset = 1'b0;

        // Single read on ch1.
        @(negedge clk);
        use_ovr = 1;
        ovr = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        set_req(1, 1, 0, 28'h0000ABC, '0);
        @(negedge clk);
        chk("s1_strobe", mem_read, 1);
        chk("s1_nowrite", mem_write, 0);
        chk("s1_addr", mem_addr, 28'h0000ABC);
        wait_ready(got, n);
        chk("s1_ready", ch_ready, 3'b010);
        chk("s1_latency", n, 4);
        chk("s1_rdata", ch_rdata, ovr);
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        chk("s1_pulse", ch_ready, 0);
        chk("s1_strobe_off", mem_read, 0);
        use_ovr = 0;

        // Simultaneous ch0 read / ch1 write after reset.
        do_reset();
        set_req(0, 1, 0, 28'h0000111, '0);
        set_req(1, 0, 1, 28'h0000222, {4{32'h1111_2222}});
        wait_ready(got, n);
        chk("sim_first", got, 0);
        chk("sim_first_rd", txn_rd, 1);
        chk("sim_first_addr", txn_addr, 28'h0000111);
        set_req(0, 0, 0, '0, '0);
        wait_ready(got, n);
        chk("sim_second", got, 1);
        chk("sim_second_wr", txn_wr, 1);
        chk("sim_second_wdata", txn_wdata, {4{32'h1111_2222}});
        chk("sim_write_keeps", ch_rdata, mdata(28'h0000111));
        set_req(0, 1, 0, 28'h0000333, '0);
        set_req(1, 0, 1, 28'h0000234, {4{32'h3333_4444}});
        wait_ready(got, n);
        chk("sim_third", got, 0);
        chk("sim_third_addr", txn_addr, 28'h0000333);
        set_req(0, 0, 0, '0, '0);
        wait_ready(got, n);
        chk("sim_fourth", got, 1);
        chk("sim_fourth_wdata", txn_wdata, {4{32'h3333_4444}});
        set_req(1, 0, 0, '0, '0);

        // Read and write together on ch0.
        @(negedge clk);
        set_req(0, 1, 1, 28'h0000444, {4{32'h5555_6666}});
        @(negedge clk);
        chk("rw_write", mem_write, 1);
        chk("rw_noread", mem_read, 0);
        wait_ready(got, n);
        chk("rw_grant", got, 0);
        chk("rw_wdata", txn_wdata, {4{32'h5555_6666}});
        chk("rw_rdata_kept", ch_rdata, mdata(28'h0000333));
        set_req(0, 0, 0, '0, '0);

        // Request withdrawn and changed while busy.
        @(negedge clk);
        set_req(2, 1, 0, 28'h0000555, '0);
        @(negedge clk);
        set_req(2, 0, 0, 28'h0000666, '0);
        @(negedge clk);
        chk("busy_addr_held", mem_addr, 28'h0000555);
        chk("busy_strobe_held", mem_read, 1);
        wait_ready(got, n);
        chk("busy_grant", got, 2);
        chk("busy_rdata", ch_rdata, mdata(28'h0000555));
        repeat (3) @(negedge clk);
        chk("busy_no_regrant", mem_read, 0);

        // Reset in the middle of a read.
        set_req(0, 1, 0, 28'h0000777, '0);
        wait_ready(got, n);
        chk("rb_pre", got, 0);
        set_req(0, 0, 0, '0, '0);
        lat = 10;
        @(negedge clk);
        set_req(1, 1, 0, 28'h0000888, '0);
        @(negedge clk);
        chk("rb_strobe", mem_read, 1);
        @(negedge clk);
        proc_reset = 1'b1;
        #1;
        chk("rb_strobe_drop", mem_read, 0);
        chk("rb_ready_low", ch_ready, 0);
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        proc_reset = 1'b0;
        lat = 4;
        set_req(0, 1, 0, 28'h0000999, '0);
        set_req(1, 1, 0, 28'h0000AAA, '0);
        wait_ready(got, n);
        chk("rb_after_grant", got, 0);
        chk("rb_after_addr", txn_addr, 28'h0000999);
        set_req(0, 0, 0, '0, '0);
        wait_ready(got, n);
        chk("rb_after_second", got, 1);
        set_req(1, 0, 0, '0, '0);

        // Stray mem_ready while idle.
        spur = 1;
        repeat (8) @(negedge clk);
        chk("spur_ready", ch_ready, 0);
        chk("spur_strobe", mem_read, 0);
        chk("spur_rdata", ch_rdata, mdata(28'h0000AAA));

        // All channels requesting continuously.
        do_reset();
        m_ptr = 0;
        m_rdata = '0;
        for (int c = 0; c < N; c++) rand_req(c);
        repeat (9) model_txn(0);

        // Randomised traffic and latency.
        rand_lat = 1;
        repeat (60) model_txn(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
